// File: rtl/powers_of_2_inner_product.sv
// Accumulates <BitDecomp(c), PowersOf2(s)> mod Q per coefficient over a k-major input
// stream, then streams the N inner products out in ascending coefficient order.
module powers_of_2_inner_product #(
  parameter int unsigned N      = 1024,
  parameter int unsigned K      = 40,
  parameter int unsigned DATA_W = 10,
  parameter int unsigned Q      = 1021,
  parameter int unsigned ACC_W  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] pow_in,
  input  logic              bit_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              busy,
  output logic              done
);
  localparam int unsigned N_W   = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned K_W   = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned SUM_W = ACC_W + 1;
  localparam int unsigned RED_W = ((DATA_W > ACC_W) ? DATA_W : ACC_W) + 1;

  localparam logic [N_W-1:0]   N_LAST = N_W'(N - 1);
  localparam logic [K_W-1:0]   K_LAST = K_W'(K - 1);
  localparam logic [SUM_W-1:0] Q_SUM  = SUM_W'(Q);
  localparam logic [RED_W-1:0] Q_RED  = RED_W'(Q);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]       state;
  logic [1:0]       state_d;
  logic [K_W-1:0]   k_cnt;
  logic [K_W-1:0]   k_d;
  logic [N_W-1:0]   n_cnt;
  logic [N_W-1:0]   n_d;
  logic             done_d;
  logic             accept;
  logic             rd_en;
  logic [N_W-1:0]   rd_addr;
  logic [ACC_W-1:0] rd_data;

  // Write stage of the read-modify-write pipeline
  logic             wr_valid;
  logic [N_W-1:0]   wr_addr;
  logic             wr_first;
  logic [ACC_W-1:0] wr_addend;
  logic [ACC_W-1:0] wr_data;

  logic [RED_W-1:0] pow_ext;
  logic [RED_W-1:0] pow_red;
  logic [ACC_W-1:0] addend;
  logic [SUM_W-1:0] sum;

  logic [ACC_W-1:0] acc_mem [N];

  assign accept = in_valid && in_ready;

  // pow_in < 2Q, so a single conditional subtraction fully reduces it
  always_comb begin
    pow_ext = RED_W'(pow_in);
    pow_red = (pow_ext >= Q_RED) ? (pow_ext - Q_RED) : pow_ext;
    addend  = bit_in ? ACC_W'(pow_red) : '0;
  end

  // Modular add of the prefetched accumulator; level 0 overwrites stale contents
  always_comb begin
    sum     = SUM_W'(rd_data) + SUM_W'(wr_addend);
    wr_data = (sum >= Q_SUM) ? ACC_W'(sum - Q_SUM) : ACC_W'(sum);
    if (wr_first) begin
      wr_data = wr_addend;
    end
  end

  // Next-state, counters and memory read control
  always_comb begin
    state_d = state;
    k_d     = k_cnt;
    n_d     = n_cnt;
    done_d  = 1'b0;
    rd_en   = 1'b0;
    rd_addr = n_cnt;
    case (state)
      S_IDLE: begin
        k_d = '0;
        n_d = '0;
        if (start) begin
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (accept) begin
          rd_en = 1'b1;
          if (n_cnt == N_LAST) begin
            n_d = '0;
            if (k_cnt == K_LAST) begin
              k_d     = '0;
              state_d = S_FLUSH;
            end else begin
              k_d = k_cnt + K_W'(1);
            end
          end else begin
            n_d = n_cnt + N_W'(1);
          end
        end
      end
      S_FLUSH: begin
        rd_en   = 1'b1;
        rd_addr = '0;
        state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (out_valid && out_ready) begin
          if (n_cnt == N_LAST) begin
            n_d     = '0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            n_d     = n_cnt + N_W'(1);
            rd_en   = 1'b1;
            rd_addr = n_cnt + N_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters, registered outputs and pipeline registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      k_cnt     <= '0;
      n_cnt     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_data   <= '0;
      wr_valid  <= 1'b0;
      wr_addr   <= '0;
      wr_first  <= 1'b0;
      wr_addend <= '0;
    end else begin
      state     <= state_d;
      k_cnt     <= k_d;
      n_cnt     <= n_d;
      in_ready  <= (state_d == S_ACCUM);
      out_valid <= (state_d == S_DRAIN);
      busy      <= (state_d != S_IDLE);
      done      <= done_d;
      if (rd_en) begin
        rd_data <= acc_mem[rd_addr];
      end
      wr_valid <= accept;
      if (accept) begin
        wr_addr   <= n_cnt;
        wr_first  <= (k_cnt == '0);
        wr_addend <= addend;
      end
    end
  end

  // Accumulator memory is intentionally not reset
  always_ff @(posedge clk) begin
    if (wr_valid) begin
      acc_mem[wr_addr] <= wr_data;
    end
  end

  assign out_data = rd_data;

endmodule

// File: tb/tb_powers_of_2_inner_product.sv
// Randomized scoreboard bench: expected inner products come from plain modular arithmetic
// over the generated (k,n) stimulus; a negedge monitor pops and compares each output.
module tb_powers_of_2_inner_product;
  localparam int unsigned N      = 4;
  localparam int unsigned K      = 3;
  localparam int unsigned DATA_W = 10;
  localparam int unsigned Q      = 1021;
  localparam int unsigned ACC_W  = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] pow_in;
  logic              bit_in;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_data;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  powers_of_2_inner_product #(
    .N(N), .K(K), .DATA_W(DATA_W), .Q(Q), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .pow_in(pow_in), .bit_in(bit_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy), .done(done)
  );

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  bit rdy_random = 1'b0;
  logic [ACC_W-1:0] exp_q [$];

  logic             prev_stall = 1'b0;
  logic             prev_done = 1'b0;
  logic [ACC_W-1:0] prev_data = '0;
  logic [ACC_W-1:0] exp_v;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
  endtask

  // Monitor: handshakes, hold-while-stalled, done pulse shape
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (prev_stall) begin
      check("hold_valid", int'(out_valid), 1);
      check("hold_data", int'(out_data), int'(prev_data));
    end
    if (out_valid && out_ready) begin
      check("output_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        check("out_data", int'(out_data), int'(exp_v));
      end
    end
    if (in_ready) check("in_ready_only_when_busy", int'(busy && !out_valid), 1);
    if (done) begin
      check("done_one_cycle", int'(prev_done), 0);
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    prev_done  = done;
  end

  always @(posedge clk) begin
    #1 out_ready = rdy_random ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  // mode: 0 random, 1 pow=1000, 2 pow=7, 3 bits all 0, 4 pre-reduction, 5 pow=3
  task automatic run(input int mode, input bit gaps, input bit timed, input int abort_after);
    int pw [K][N];
    int bt [K][N];
    int idx, guard, cyc0, d0, s;
    bit acc;
    for (int k = 0; k < int'(K); k++) begin
      for (int n = 0; n < int'(N); n++) begin
        pw[k][n] = int'($urandom_range(0, (1 << DATA_W) - 1));
        bt[k][n] = int'($urandom_range(0, 1));
        case (mode)
          1: begin pw[k][n] = 1000; bt[k][n] = 1; end
          2: begin pw[k][n] = 7;    bt[k][n] = 1; end
          3: bt[k][n] = 0;
          4: begin
            bt[k][n] = (k == 0) ? 1 : 0;
            if (k == 0) pw[k][n] = (n % 2 == 1) ? 1020 : 1023;
          end
          5: begin pw[k][n] = 3; bt[k][n] = 1; end
          default: ;
        endcase
      end
    end
    if (abort_after < 0) begin
      for (int n = 0; n < int'(N); n++) begin
        s = 0;
        for (int k = 0; k < int'(K); k++) s += bt[k][n] * pw[k][n];
        exp_q.push_back(ACC_W'(s % int'(Q)));
      end
    end

    @(posedge clk); #1;
    start = 1'b1;
    cyc0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    idx = 0;
    guard = 0;
    while (idx < int'(N * K)) begin
      if (abort_after >= 0 && idx == abort_after) break;
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      pow_in   = DATA_W'(pw[idx / int'(N)][idx % int'(N)]);
      bit_in   = bt[idx / int'(N)][idx % int'(N)][0];
      if (gaps) start = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      guard++;
      if (timed && guard == 1) check("in_ready_after_start", int'(in_ready), 1);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      if (guard > 20 * int'(N * K) + 50) begin
        check("accum_timeout", idx, int'(N * K));
        break;
      end
    end
    in_valid = 1'b0;
    start = 1'b0;

    if (abort_after >= 0) begin
      reset = 1'b1;
      @(negedge clk);
      check("abort_in_ready", int'(in_ready), 0);
      check("abort_busy", int'(busy), 0);
      check("abort_out_valid", int'(out_valid), 0);
      @(posedge clk); #1;
      reset = 1'b0;
      return;
    end

    @(negedge clk);
    check("in_ready_after_last", int'(in_ready), 0);
    d0 = done_cnt;
    guard = 0;
    while (done_cnt == d0 && guard < 20 * int'(N) + 100) begin
      @(posedge clk); #1;
      start = busy ? (gaps && $urandom_range(0, 3) == 0) : 1'b0;
      guard++;
    end
    start = 1'b0;
    check("done_seen", done_cnt - d0, 1);
    if (timed) check("start_to_done_cycles", done_cyc - cyc0, int'(N * K + N + 3));
    repeat (3) @(negedge clk);
    check("done_once", done_cnt - d0, 1);
    check("queue_drained", exp_q.size(), 0);
    check("idle_busy", int'(busy), 0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    pow_in = '0;
    bit_in = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("reset_in_ready", int'(in_ready), 0);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_data", int'(out_data), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    run(1, 1'b0, 1'b1, -1);
    run(4, 1'b0, 1'b1, -1);
    run(2, 1'b0, 1'b0, -1);
    run(3, 1'b0, 1'b0, -1);
    run(0, 1'b0, 1'b0, int'(N) + 2);
    run(5, 1'b1, 1'b0, -1);
    rdy_random = 1'b1;
    for (int r = 0; r < 8; r++) run(0, 1'b1, 1'b0, -1);
    run(5, 1'b1, 1'b0, -1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/powers_of_2_inner_product.md
# powers_of_2_inner_product

Downstream consumer of the powers-of-two expansion stage in the homomorphic-encryption datapath. It takes the k-major stream of PowersOf2(s) elements (K levels × N coefficients) with the matching BitDecomp(c) bits. For every coefficient it accumulates bit·power modulo Q, then streams out the N per-coefficient inner products. The result is the relinearisation/decryption term ⟨BitDecomp(c), PowersOf2(s)⟩ mod Q.

## Interface
Parameters:
- N, 1024, coefficients per level; N ≥ 4.
- K, 40, decomposition levels.
- DATA_W, 10, width of incoming powers-of-two element.
- Q, 1021, modulus; 2 ≤ Q < 2^ACC_W and 2^DATA_W < 2·Q.
- ACC_W, 10, accumulator/output width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begins a run when sampled high in IDLE.
- in_valid  in  1  pow_in/bit_in valid.
- in_ready  out  1  high only in ACCUM.
- pow_in  in  DATA_W  PowersOf2 element for (k,n), k-major order (n fastest).
- bit_in  in  1  BitDecomp bit for the same (k,n).
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts.
- out_data  out  ACC_W  accumulated value for coefficient n, n = 0..N-1 ascending.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last output handshake.

## Operation
- States: IDLE → ACCUM → FLUSH → DRAIN → IDLE.
- IDLE: counters k=0, n=0. start=1 moves the block to ACCUM next cycle. start is ignored in every other state.
- ACCUM: an input is accepted on in_valid && in_ready. The accepted input is processed as follows.
  - addend = bit_in ? (pow_in ≥ Q ? pow_in − Q : pow_in) : 0.
  - If k==0: acc[n] ← addend. There is no clear pass; stale memory contents are overwritten.
  - Otherwise: acc[n] ← (acc[n] + addend), minus Q if the sum ≥ Q. The sum is computed at ACC_W+1 bits.
  - n increments per accept. When n wraps N−1→0, k increments. The accept with k=K−1, n=N−1 moves the block to FLUSH.
- Accumulator: one N×ACC_W array, read-modify-write through a one-cycle pipeline (accept cycle reads, next cycle writes).
  - A coefficient is revisited N ≥ 4 accepts later, so no read-after-write hazard exists.
  - No forwarding path is required.
- FLUSH: one cycle. The final pipelined write completes and the read of acc[0] is issued.
- DRAIN: out_valid=1 with out_data=acc[n].
  - On out_valid && out_ready, n increments and the next entry is presented the following cycle.
  - out_valid stays high through consecutive handshakes; the read is prefetched so there are no bubbles.
  - out_data is stable while out_ready=0.
  - After the handshake with n=N−1: out_valid=0, done=1 for one cycle, state returns to IDLE.
- in_valid gaps in ACCUM stall the counters and must not corrupt the pipeline: the write stage still retires the last accepted element.
- reset (any time, including mid-ACCUM or mid-DRAIN): the block returns immediately to IDLE, k=n=0, and the pipeline valid is cleared. Accumulator memory is not cleared.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, busy=0, done=0.
- start sampled in IDLE at cycle t → in_ready=1 from t+1.
- Throughput: one input per cycle in ACCUM; one output per cycle in DRAIN when out_ready=1.
- Last input accepted at cycle t → FLUSH at t+1 → out_valid=1 at t+2.
- A run with no stalls takes N·K + N + 3 cycles from start to done.
- in_ready falls the cycle after the last accept and is never high outside ACCUM.

## Test plan
- Defaults, all pow_in=1, bit_in=1, out_ready=1 → 1024 outputs each = 40; done pulses exactly once at cycle N·K+N+3 after start.
- N=4, K=3, pow_in=1000, bits all 1 → each output 958 (1000, then 2000−1021=979, then 1979−1021=958).
- N=4, K=1, pow_in=1023, bit_in=1 → outputs 2 (pre-reduction of pow_in ≥ Q); pow_in=1020 → 1020.
- Run with all bits 1 and pow_in=7, then a second run with all bit_in=0 → second run outputs all 0 (k=0 overwrite of stale memory).
- Random in_valid gaps and out_ready toggling (50%), random pow_in/bit_in vs scoreboard → exact match; out_data held while out_ready=0; no lost or duplicated outputs.
- Assert reset mid-ACCUM (k=1, n=2), then start a clean run with pow_in=3, bits 1, N=4, K=2 → outputs 6; start pulses during ACCUM/DRAIN ignored.
